// File: rtl/dma_pkg.sv
// Package: dma_pkg
// Shared definitions for burst_dma_engine and its burst counter.
//   BEAT_BYTES : bytes moved per bus beat (one 32-bit word)
//   BSIZE_W    : width of the bus burst_size field (beats-1)
//   BEAT_W     : width that holds a beat count of 1..256
//   dma_state_e: engine FSM states, fixed encodings kept from the legacy design
package dma_pkg;

  localparam int unsigned BEAT_BYTES = 4;
  localparam int unsigned BSIZE_W    = 8;
  localparam int unsigned BEAT_W     = 9;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFETCH  = 3'd1,
    ST_REQUEST   = 3'd2,
    ST_HANDSHAKE = 3'd3,
    ST_WR_DATA   = 3'd4,
    ST_RD_DATA   = 3'd5,
    ST_NEXT      = 3'd6
  } dma_state_e;

endpackage

// File: rtl/dma_burst_counter.sv
// Module: dma_burst_counter
// Remaining-word and per-burst beat counters for burst_dma_engine.
//   clock, n_reset   : system clock, asynchronous active-low reset
//   i_load, i_count  : latch a new transfer length (clears beat state)
//   i_burst_start    : take min(remaining, MAX_BURST) beats for a new burst
//   i_beat           : one beat of the current burst has been moved
//   o_burst_len      : min(remaining, MAX_BURST), valid before i_burst_start
//   o_burst_len_q    : length of the burst currently in flight
//   o_beat_avail     : beats of the current burst still outstanding
//   o_last_beat      : exactly one beat outstanding
//   o_rem_zero       : no words left to schedule after the current burst
module dma_burst_counter
  import dma_pkg::*;
#(
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = 10
) (
  input  logic              clock,
  input  logic              n_reset,
  input  logic              i_load,
  input  logic [CNT_W-1:0]  i_count,
  input  logic              i_burst_start,
  input  logic              i_beat,
  output logic [BEAT_W-1:0] o_burst_len,
  output logic [BEAT_W-1:0] o_burst_len_q,
  output logic              o_beat_avail,
  output logic              o_last_beat,
  output logic              o_rem_zero
);

  logic [CNT_W-1:0]  r_remaining;
  logic [BEAT_W-1:0] r_beats;
  logic [BEAT_W-1:0] r_len;
  logic              w_cap;

  // Compare in 32 bits so a narrow CNT_W cannot truncate MAX_BURST.
  assign w_cap         = (32'(r_remaining) >= 32'(MAX_BURST));
  assign o_burst_len   = w_cap ? BEAT_W'(MAX_BURST) : BEAT_W'(r_remaining);
  assign o_burst_len_q = r_len;
  assign o_beat_avail  = (r_beats != '0);
  assign o_last_beat   = (r_beats == BEAT_W'(1));
  assign o_rem_zero    = (r_remaining == '0);

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_remaining <= '0;
      r_beats     <= '0;
      r_len       <= '0;
    end else if (i_load) begin
      r_remaining <= i_count;
      r_beats     <= '0;
      r_len       <= '0;
    end else if (i_burst_start) begin
      r_remaining <= r_remaining - CNT_W'(o_burst_len);
      r_beats     <= o_burst_len;
      r_len       <= o_burst_len;
    end else if (i_beat && o_beat_avail) begin
      r_beats     <= r_beats - BEAT_W'(1);
    end
  end

endmodule

// File: rtl/burst_dma_engine.sv
// Module: burst_dma_engine
// Multi-word DMA master between the local dual-port buffer and the shared bus.
// Moves word_count words as bursts of up to MAX_BURST beats (write: buffer->bus,
// read: bus->buffer), with address auto-increment, done and error reporting.
//   clock, n_reset             : system clock, asynchronous active-low reset
//   start_write / start_read   : 1-cycle start strobes (write has priority)
//   bus_start_address, buf_start_address, word_count, byte_enable : transfer setup
//   dma_busy / dma_done / dma_error : status (done/error are 1-cycle pulses)
//   bufferAddress, dataIn, writeEnable, dataOut : buffer port (1-cycle read latency)
//   address_dataIN, end_transactionIN, data_validIN, busyIN, errorIN : bus inputs
//   address_dataOUT, byte_enableOUT, burst_sizeOUT, read_n_writeOUT,
//   begin_transactionOUT, end_transactionOUT, data_validOUT, busyOUT : bus outputs
//   request / granted          : arbiter handshake
module burst_dma_engine
  import dma_pkg::*;
#(
  parameter int unsigned BUF_AW    = 9,
  parameter int unsigned MAX_BURST = 16,
  parameter int unsigned CNT_W     = 10
) (
  input  logic               clock,
  input  logic               n_reset,
  input  logic               start_write,
  input  logic               start_read,
  input  logic [31:0]        bus_start_address,
  input  logic [BUF_AW-1:0]  buf_start_address,
  input  logic [CNT_W-1:0]   word_count,
  input  logic [3:0]         byte_enable,
  output logic               dma_busy,
  output logic               dma_done,
  output logic               dma_error,
  output logic [BUF_AW-1:0]  bufferAddress,
  output logic [31:0]        dataIn,
  output logic               writeEnable,
  input  logic [31:0]        dataOut,
  input  logic [31:0]        address_dataIN,
  input  logic               end_transactionIN,
  input  logic               data_validIN,
  input  logic               busyIN,
  input  logic               errorIN,
  output logic [31:0]        address_dataOUT,
  output logic [3:0]         byte_enableOUT,
  output logic [BSIZE_W-1:0] burst_sizeOUT,
  output logic               read_n_writeOUT,
  output logic               begin_transactionOUT,
  output logic               end_transactionOUT,
  output logic               data_validOUT,
  output logic               busyOUT,
  output logic               request,
  input  logic               granted
);

  dma_state_e        r_state;
  dma_state_e        w_next;
  logic [31:0]       r_bus_addr;
  logic [BUF_AW-1:0] r_buf_addr;
  logic [3:0]        r_be;
  logic              r_rd;
  logic [31:0]       r_out_reg;

  logic              w_load;
  logic              w_burst_start;
  logic              w_beat;
  logic              w_grab;
  logic              w_bus_step;
  logic [BEAT_W-1:0] w_len;
  logic [BEAT_W-1:0] w_len_q;
  logic              w_beat_avail;
  logic              w_last;
  logic              w_rem_zero;

  dma_burst_counter #(
    .MAX_BURST (MAX_BURST),
    .CNT_W     (CNT_W)
  ) u_cnt (
    .clock         (clock),
    .n_reset       (n_reset),
    .i_load        (w_load),
    .i_count       (word_count),
    .i_burst_start (w_burst_start),
    .i_beat        (w_beat),
    .o_burst_len   (w_len),
    .o_burst_len_q (w_len_q),
    .o_beat_avail  (w_beat_avail),
    .o_last_beat   (w_last),
    .o_rem_zero    (w_rem_zero)
  );

  // r_buf_addr is the buffer index of the word held in r_out_reg during a write.
  // With 1-cycle buffer latency, dataOut must already carry the following word,
  // so the address presented runs one ahead, two ahead on an accepted beat.
  always_comb begin
    w_next               = r_state;
    w_load               = 1'b0;
    w_burst_start        = 1'b0;
    w_beat               = 1'b0;
    w_grab               = 1'b0;
    w_bus_step           = 1'b0;
    dma_busy             = (r_state != ST_IDLE);
    dma_done             = 1'b0;
    dma_error            = 1'b0;
    bufferAddress        = '0;
    dataIn               = '0;
    writeEnable          = 1'b0;
    address_dataOUT      = '0;
    byte_enableOUT       = '0;
    burst_sizeOUT        = '0;
    read_n_writeOUT      = 1'b0;
    begin_transactionOUT = 1'b0;
    end_transactionOUT   = 1'b0;
    data_validOUT        = 1'b0;
    busyOUT              = 1'b0;
    request              = 1'b0;

    if (errorIN && (r_state != ST_IDLE)) begin
      end_transactionOUT = 1'b1;
      dma_error          = 1'b1;
      w_next             = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start_write || start_read) begin
            w_load = 1'b1;
            if (word_count == '0)  w_next = ST_NEXT;
            else if (start_write)  w_next = ST_PREFETCH;
            else                   w_next = ST_REQUEST;
          end
        end
        ST_PREFETCH: begin
          bufferAddress = r_buf_addr;
          w_next        = ST_REQUEST;
        end
        ST_REQUEST: begin
          request = 1'b1;
          if (!r_rd) bufferAddress = r_buf_addr;
          if (granted) begin
            w_grab = !r_rd;
            w_next = ST_HANDSHAKE;
          end
        end
        ST_HANDSHAKE: begin
          begin_transactionOUT = 1'b1;
          address_dataOUT      = r_bus_addr;
          byte_enableOUT       = r_be;
          burst_sizeOUT        = BSIZE_W'(w_len - BEAT_W'(1));
          read_n_writeOUT      = r_rd;
          w_burst_start        = 1'b1;
          if (!r_rd) bufferAddress = r_buf_addr + BUF_AW'(1);
          w_next = r_rd ? ST_RD_DATA : ST_WR_DATA;
        end
        ST_WR_DATA: begin
          data_validOUT   = 1'b1;
          address_dataOUT = r_out_reg;
          w_beat          = !busyIN;
          bufferAddress   = busyIN ? r_buf_addr + BUF_AW'(1) : r_buf_addr + BUF_AW'(2);
          if (!busyIN && w_last) begin
            end_transactionOUT = 1'b1;
            w_next             = ST_NEXT;
          end
        end
        ST_RD_DATA: begin
          bufferAddress = r_buf_addr;
          dataIn        = address_dataIN;
          if (data_validIN && w_beat_avail) begin
            writeEnable = 1'b1;
            w_beat      = 1'b1;
          end
          if (end_transactionIN) w_next = ST_NEXT;
        end
        ST_NEXT: begin
          w_bus_step = 1'b1;
          if (w_rem_zero) begin
            dma_done = 1'b1;
            w_next   = ST_IDLE;
          end else begin
            w_next   = r_rd ? ST_REQUEST : ST_PREFETCH;
          end
        end
        default: w_next = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clock or negedge n_reset) begin
    if (!n_reset) begin
      r_state    <= ST_IDLE;
      r_bus_addr <= '0;
      r_buf_addr <= '0;
      r_be       <= '0;
      r_rd       <= 1'b0;
      r_out_reg  <= '0;
    end else begin
      r_state <= w_next;
      if (w_load) begin
        r_bus_addr <= bus_start_address;
        r_buf_addr <= buf_start_address;
        r_be       <= byte_enable;
        r_rd       <= !start_write;
      end
      if (w_grab) r_out_reg <= dataOut;
      if (w_beat) begin
        r_buf_addr <= r_buf_addr + BUF_AW'(1);
        if (!r_rd) r_out_reg <= dataOut;
      end
      if (w_bus_step) r_bus_addr <= r_bus_addr + 32'(w_len_q) * BEAT_BYTES;
    end
  end

endmodule

// File: tb/tb_burst_dma_engine.sv
module tb_burst_dma_engine;

  logic        clock = 1'b0;
  logic        n_reset;
  logic        start_write, start_read;
  logic [31:0] bus_start_address;
  logic [8:0]  buf_start_address;
  logic [9:0]  word_count;
  logic [3:0]  byte_enable;
  logic        dma_busy, dma_done, dma_error;
  logic [8:0]  bufferAddress;
  logic [31:0] dataIn;
  logic        writeEnable;
  logic [31:0] dataOut;
  logic [31:0] address_dataIN;
  logic        end_transactionIN, data_validIN, busyIN, errorIN;
  logic [31:0] address_dataOUT;
  logic [3:0]  byte_enableOUT;
  logic [7:0]  burst_sizeOUT;
  logic        read_n_writeOUT, begin_transactionOUT, end_transactionOUT;
  logic        data_validOUT, busyOUT, request, granted;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clock = ~clock;

  burst_dma_engine #(
    .BUF_AW    (9),
    .MAX_BURST (16),
    .CNT_W     (10)
  ) dut (
    .clock                (clock),
    .n_reset              (n_reset),
    .start_write          (start_write),
    .start_read           (start_read),
    .bus_start_address    (bus_start_address),
    .buf_start_address    (buf_start_address),
    .word_count           (word_count),
    .byte_enable          (byte_enable),
    .dma_busy             (dma_busy),
    .dma_done             (dma_done),
    .dma_error            (dma_error),
    .bufferAddress        (bufferAddress),
    .dataIn               (dataIn),
    .writeEnable          (writeEnable),
    .dataOut              (dataOut),
    .address_dataIN       (address_dataIN),
    .end_transactionIN    (end_transactionIN),
    .data_validIN         (data_validIN),
    .busyIN               (busyIN),
    .errorIN              (errorIN),
    .address_dataOUT      (address_dataOUT),
    .byte_enableOUT       (byte_enableOUT),
    .burst_sizeOUT        (burst_sizeOUT),
    .read_n_writeOUT      (read_n_writeOUT),
    .begin_transactionOUT (begin_transactionOUT),
    .end_transactionOUT   (end_transactionOUT),
    .data_validOUT        (data_validOUT),
    .busyOUT              (busyOUT),
    .request              (request),
    .granted              (granted)
  );

  // Dual-port buffer model: bench preload port, DUT write port, 1-cycle read.
  logic [31:0] mem [0:511];
  logic        tb_we;
  logic [8:0]  tb_waddr;
  logic [31:0] tb_wdata;

  always @(posedge clock) begin
    if (tb_we)            mem[tb_waddr] <= tb_wdata;
    else if (writeEnable) mem[bufferAddress] <= dataIn;
    dataOut <= mem[bufferAddress];
  end

  task automatic check_value(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic cyc();
    @(negedge clock);
  endtask

  task automatic preload(input logic [8:0] a, input logic [31:0] d);
    tb_we = 1'b1; tb_waddr = a; tb_wdata = d;
    cyc();
    tb_we = 1'b0;
  endtask

  task automatic start_xfer(input bit wr, input logic [31:0] bus, input logic [8:0] bufa,
                            input logic [9:0] cnt);
    bus_start_address = bus; buf_start_address = bufa; word_count = cnt;
    start_write = wr; start_read = !wr;
    cyc();
    start_write = 1'b0; start_read = 1'b0;
  endtask

  task automatic wait_hs(input string tag);
    for (int i = 0; i < 40 && !begin_transactionOUT; i++) cyc();
    check_value({tag, " handshake"}, 32'(begin_transactionOUT), 32'd1);
  endtask

  task automatic wait_done(input string tag);
    for (int i = 0; i < 40 && !dma_done; i++) cyc();
    check_value({tag, " done"}, 32'(dma_done), 32'd1);
  endtask

  logic [8:0] t4_addr [0:3];

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    n_reset = 1'b0; start_write = 1'b0; start_read = 1'b0;
    bus_start_address = '0; buf_start_address = '0; word_count = '0; byte_enable = 4'h5;
    address_dataIN = '0; end_transactionIN = 1'b0; data_validIN = 1'b0;
    busyIN = 1'b0; errorIN = 1'b0; granted = 1'b1;
    tb_we = 1'b0; tb_waddr = '0; tb_wdata = '0;
    t4_addr[0] = 9'h1FE; t4_addr[1] = 9'h1FF; t4_addr[2] = 9'h000; t4_addr[3] = 9'h001;

    // Reset state
    cyc();
    check_value("rst busy", 32'(dma_busy), 32'd0);
    check_value("rst request", 32'(request), 32'd0);
    check_value("rst adout", address_dataOUT, 32'h0);
    check_value("rst bufaddr", 32'(bufferAddress), 32'h0);
    check_value("rst busyOUT", 32'(busyOUT), 32'd0);
    n_reset = 1'b1;
    cyc();

    // 1: 3-word write, cycle-exact
    preload(9'h000, 32'hAAAA_0001);
    preload(9'h001, 32'hBBBB_0002);
    preload(9'h002, 32'hCCCC_0003);
    start_xfer(1'b1, 32'h0000_1000, 9'h000, 10'd3);
    check_value("t1 prefetch busy", 32'(dma_busy), 32'd1);
    check_value("t1 prefetch req", 32'(request), 32'd0);
    cyc();
    check_value("t1 request", 32'(request), 32'd1);
    cyc();
    check_value("t1 hs begin", 32'(begin_transactionOUT), 32'd1);
    check_value("t1 hs addr", address_dataOUT, 32'h0000_1000);
    check_value("t1 hs size", 32'(burst_sizeOUT), 32'd2);
    check_value("t1 hs rnw", 32'(read_n_writeOUT), 32'd0);
    check_value("t1 hs be", 32'(byte_enableOUT), 32'h5);
    cyc();
    check_value("t1 beatA", address_dataOUT, 32'hAAAA_0001);
    check_value("t1 beatA valid", 32'(data_validOUT), 32'd1);
    check_value("t1 beatA end", 32'(end_transactionOUT), 32'd0);
    check_value("t1 beatA be", 32'(byte_enableOUT), 32'h0);
    cyc();
    check_value("t1 beatB", address_dataOUT, 32'hBBBB_0002);
    check_value("t1 beatB end", 32'(end_transactionOUT), 32'd0);
    cyc();
    check_value("t1 beatC", address_dataOUT, 32'hCCCC_0003);
    check_value("t1 beatC end", 32'(end_transactionOUT), 32'd1);
    cyc();
    check_value("t1 done", 32'(dma_done), 32'd1);
    cyc();
    check_value("t1 idle busy", 32'(dma_busy), 32'd0);
    check_value("t1 idle done", 32'(dma_done), 32'd0);

    // 2: 20-word write splits into 16 + 4
    for (int i = 0; i < 20; i++) preload(9'(9'h010 + i), 32'hD000_0000 + 32'(i));
    start_xfer(1'b1, 32'h0000_2000, 9'h010, 10'd20);
    wait_hs("t2 b1");
    check_value("t2 b1 addr", address_dataOUT, 32'h0000_2000);
    check_value("t2 b1 size", 32'(burst_sizeOUT), 32'd15);
    cyc();
    for (int i = 0; i < 16; i++) begin
      check_value($sformatf("t2 b1 beat%0d", i), address_dataOUT, 32'hD000_0000 + 32'(i));
      check_value($sformatf("t2 b1 end%0d", i), 32'(end_transactionOUT), 32'(i == 15));
      cyc();
    end
    check_value("t2 mid done", 32'(dma_done), 32'd0);
    wait_hs("t2 b2");
    check_value("t2 b2 addr", address_dataOUT, 32'h0000_2040);
    check_value("t2 b2 size", 32'(burst_sizeOUT), 32'd3);
    cyc();
    for (int i = 0; i < 4; i++) begin
      check_value($sformatf("t2 b2 beat%0d", i), address_dataOUT, 32'hD000_0010 + 32'(i));
      check_value($sformatf("t2 b2 end%0d", i), 32'(end_transactionOUT), 32'(i == 3));
      cyc();
    end
    check_value("t2 done", 32'(dma_done), 32'd1);
    cyc();

    // 3: busyIN stall on beat 2; a start_read while busy is ignored
    preload(9'h040, 32'hE000_0000);
    preload(9'h041, 32'hE000_0001);
    preload(9'h042, 32'hE000_0002);
    start_xfer(1'b1, 32'h0000_5000, 9'h040, 10'd3);
    wait_hs("t3");
    cyc();
    check_value("t3 beat0", address_dataOUT, 32'hE000_0000);
    cyc();
    busyIN = 1'b1;
    for (int k = 0; k < 3; k++) begin
      start_read = (k == 0);
      #1;
      check_value($sformatf("t3 stall%0d data", k), address_dataOUT, 32'hE000_0001);
      check_value($sformatf("t3 stall%0d end", k), 32'(end_transactionOUT), 32'd0);
      check_value($sformatf("t3 stall%0d valid", k), 32'(data_validOUT), 32'd1);
      cyc();
      start_read = 1'b0;
    end
    busyIN = 1'b0;
    #1;
    check_value("t3 beat1", address_dataOUT, 32'hE000_0001);
    cyc();
    check_value("t3 beat2", address_dataOUT, 32'hE000_0002);
    check_value("t3 beat2 end", 32'(end_transactionOUT), 32'd1);
    cyc();
    check_value("t3 done", 32'(dma_done), 32'd1);
    cyc();
    cyc();
    check_value("t3 no relaunch busy", 32'(dma_busy), 32'd0);
    check_value("t3 no relaunch req", 32'(request), 32'd0);

    // 4: 4-word read wrapping the buffer; last beat shares the end cycle
    start_xfer(1'b0, 32'h0000_3000, 9'h1FE, 10'd4);
    wait_hs("t4");
    check_value("t4 hs rnw", 32'(read_n_writeOUT), 32'd1);
    check_value("t4 hs size", 32'(burst_sizeOUT), 32'd3);
    check_value("t4 hs addr", address_dataOUT, 32'h0000_3000);
    cyc();
    for (int i = 0; i < 4; i++) begin
      data_validIN = 1'b1;
      address_dataIN = 32'(i + 1);
      end_transactionIN = (i == 3);
      #1;
      check_value($sformatf("t4 we%0d", i), 32'(writeEnable), 32'd1);
      check_value($sformatf("t4 addr%0d", i), 32'(bufferAddress), 32'(t4_addr[i]));
      check_value($sformatf("t4 din%0d", i), dataIn, 32'(i + 1));
      cyc();
    end
    data_validIN = 1'b0; end_transactionIN = 1'b0;
    check_value("t4 done", 32'(dma_done), 32'd1);
    cyc();
    check_value("t4 mem1FE", mem[9'h1FE], 32'd1);
    check_value("t4 mem1FF", mem[9'h1FF], 32'd2);
    check_value("t4 mem000", mem[9'h000], 32'd3);
    check_value("t4 mem001", mem[9'h001], 32'd4);

    // 4b: excess read beat is not written
    preload(9'h0A1, 32'h0000_5555);
    start_xfer(1'b0, 32'h0000_3100, 9'h0A0, 10'd1);
    wait_hs("t4b");
    check_value("t4b size", 32'(burst_sizeOUT), 32'd0);
    cyc();
    data_validIN = 1'b1; address_dataIN = 32'h77;
    #1;
    check_value("t4b we beat", 32'(writeEnable), 32'd1);
    cyc();
    address_dataIN = 32'h88;
    #1;
    check_value("t4b we excess", 32'(writeEnable), 32'd0);
    cyc();
    data_validIN = 1'b0; end_transactionIN = 1'b1;
    cyc();
    end_transactionIN = 1'b0;
    wait_done("t4b");
    cyc();
    check_value("t4b memA0", mem[9'h0A0], 32'h77);
    check_value("t4b memA1", mem[9'h0A1], 32'h0000_5555);

    // 5: errorIN during beat 2 of a read
    start_xfer(1'b0, 32'h0000_4000, 9'h080, 10'd4);
    wait_hs("t5");
    cyc();
    data_validIN = 1'b1; address_dataIN = 32'h11;
    cyc();
    address_dataIN = 32'h22; errorIN = 1'b1;
    #1;
    check_value("t5 err end", 32'(end_transactionOUT), 32'd1);
    check_value("t5 err pulse", 32'(dma_error), 32'd1);
    cyc();
    data_validIN = 1'b0; errorIN = 1'b0;
    #1;
    check_value("t5 after err", 32'(dma_error), 32'd0);
    check_value("t5 after end", 32'(end_transactionOUT), 32'd0);
    check_value("t5 idle busy", 32'(dma_busy), 32'd0);
    check_value("t5 idle req", 32'(request), 32'd0);
    check_value("t5 mem80", mem[9'h080], 32'h11);

    // 6: zero-length write, then reset mid-burst
    start_xfer(1'b1, 32'h0000_6000, 9'h000, 10'd0);
    check_value("t6 zero done", 32'(dma_done), 32'd1);
    check_value("t6 zero req", 32'(request), 32'd0);
    cyc();
    check_value("t6 zero idle", 32'(dma_busy), 32'd0);
    check_value("t6 zero no req", 32'(request), 32'd0);
    start_xfer(1'b1, 32'h0000_7000, 9'h000, 10'd5);
    wait_hs("t6 rst");
    cyc();
    cyc();
    check_value("t6 mid valid", 32'(data_validOUT), 32'd1);
    n_reset = 1'b0;
    #1;
    check_value("t6 rst valid", 32'(data_validOUT), 32'd0);
    check_value("t6 rst end", 32'(end_transactionOUT), 32'd0);
    check_value("t6 rst busy", 32'(dma_busy), 32'd0);
    check_value("t6 rst adout", address_dataOUT, 32'h0);
    check_value("t6 rst bufaddr", 32'(bufferAddress), 32'h0);
    cyc();
    n_reset = 1'b1;
    cyc();
    check_value("t6 post rst busy", 32'(dma_busy), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
